// File: rtl/dcr_dmem_arbiter_if.sv
// Core-side and RAM-side bus of the dual-core data-memory arbiter.
interface dcr_dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              stall0, stall1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  // arbiter side
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, rdata0, rdata1,
           ram_wren, ram_addr, ram_data
  );

  // cores + RAM side
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, rdata0, rdata1,
           ram_wren, ram_addr, ram_data
  );
endinterface

// File: rtl/dcr_dmem_arbiter.sv
// Two-core data RAM arbiter: round-robin with bounded lock ownership for
// read-modify-write sequences; read data returned one clken cycle after grant.
module dcr_dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clken,
  dcr_dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state, state_n;
  logic              lg, lg_n;         // last granted core
  logic [3:0]        lcnt, lcnt_n;
  logic              rtag0, rtag1;     // read in flight, owned by core X
  logic              g0, g1;
  logic              go;
  logic [ADDR_W-1:0] addr_m;
  logic [DATA_W-1:0] data_m;
  logic              wren_m;

  // grants are suppressed while frozen or held in reset
  assign go = clken & rst;

  // combinational grant: round-robin in IDLE, owner-only while locked
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          g0 = lg;
          g1 = ~lg;
        end else begin
          g0 = bus.req0;
          g1 = bus.req1;
        end
      end
      OWN0:    g0 = bus.req0;
      OWN1:    g1 = bus.req1;
      default: ;
    endcase
    g0 = g0 & go;
    g1 = g1 & go;
  end

  // next state, last-grant pointer and lock counter
  always_comb begin
    state_n = state;
    lg_n    = lg;
    lcnt_n  = lcnt;
    if (g0)      lg_n = 1'b0;
    else if (g1) lg_n = 1'b1;
    case (state)
      IDLE: begin
        lcnt_n = 4'd0;
        if (g0 && bus.lock0) begin
          state_n = OWN0;
          lcnt_n  = 4'd1;
        end else if (g1 && bus.lock1) begin
          state_n = OWN1;
          lcnt_n  = 4'd1;
        end
      end
      OWN0: begin
        lcnt_n = lcnt + 4'd1;
        if (!bus.lock0) begin
          state_n = IDLE;
        end else if (lcnt_n == 4'(MAX_LOCK)) begin
          // forced release: core1 wins the next contention
          state_n = IDLE;
          lg_n    = 1'b0;
        end
      end
      OWN1: begin
        lcnt_n = lcnt + 4'd1;
        if (!bus.lock1) begin
          state_n = IDLE;
        end else if (lcnt_n == 4'(MAX_LOCK)) begin
          state_n = IDLE;
          lg_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // arbiter state advances only on clken cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lg    <= 1'b1;
      lcnt  <= 4'd0;
    end else if (clken) begin
      state <= state_n;
      lg    <= lg_n;
      lcnt  <= lcnt_n;
    end
  end

  // read owner tags: held across clken=0 so the return is not lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rtag0 <= 1'b0;
      rtag1 <= 1'b0;
    end else if (clken) begin
      rtag0 <= g0 & ~bus.we0;
      rtag1 <= g1 & ~bus.we1;
    end
  end

  // RAM port follows the granted core, parked at zero otherwise
  always_comb begin
    addr_m = '0;
    data_m = '0;
    wren_m = 1'b0;
    if (g0) begin
      addr_m = bus.addr0;
      data_m = bus.wdata0;
      wren_m = bus.we0;
    end else if (g1) begin
      addr_m = bus.addr1;
      data_m = bus.wdata1;
      wren_m = bus.we1;
    end
  end

  assign bus.ram_addr = addr_m;
  assign bus.ram_data = data_m;
  assign bus.ram_wren = wren_m;
  assign bus.gnt0     = g0;
  assign bus.gnt1     = g1;
  assign bus.stall0   = bus.req0 & ~g0;
  assign bus.stall1   = bus.req1 & ~g1;
  assign bus.rvalid0  = rtag0 & clken;
  assign bus.rvalid1  = rtag1 & clken;
  assign bus.rdata0   = (rtag0 & clken) ? bus.ram_q : '0;
  assign bus.rdata1   = (rtag1 & clken) ? bus.ram_q : '0;
endmodule

// File: tb/tb_dcr_dmem_arbiter.sv
// Randomized bench for dcr_dmem_arbiter against an ownership/queue-level model.
module tb_dcr_dmem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst;
  logic clken;
  int   nchk = 0;
  int   nerr = 0;

  dcr_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dcr_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst), .clken(clken), .bus(bus)
  );

  always #5 clk = ~clk;

  // synchronous RAM; integrator freezes it with clken
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (clken) begin
      if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_data;
      bus.ram_q <= ram[bus.ram_addr];
    end
  end

  // reference model: who owns, how long, who went last, what each core awaits
  int            m_own;   // -1 none, else owning core
  int            m_cnt;
  int            m_lg;
  bit            m_pend [2];
  logic [DW-1:0] m_pdat [2];
  logic [DW-1:0] shadow [256];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_cnt = 0; m_lg = 1;
    m_pend[0] = 0; m_pend[1] = 0;
    m_pdat[0] = '0; m_pdat[1] = '0;
  endtask

  // one clock: predict, check at negedge, then advance the model past posedge
  task automatic cyc();
    int g;
    bit r [2], w [2], l [2], rv [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    r[0] = bus.req0;  r[1] = bus.req1;
    w[0] = bus.we0;   w[1] = bus.we1;
    l[0] = bus.lock0; l[1] = bus.lock1;
    a[0] = bus.addr0; a[1] = bus.addr1;
    d[0] = bus.wdata0; d[1] = bus.wdata1;
    g = -1;
    if (rst && clken) begin
      if (m_own < 0) begin
        if (r[0] && r[1]) g = 1 - m_lg;
        else if (r[0])    g = 0;
        else if (r[1])    g = 1;
      end else if (r[m_own]) g = m_own;
    end
    rv[0] = m_pend[0] && clken;
    rv[1] = m_pend[1] && clken;
    @(negedge clk);
    chk("gnt0",    32'(bus.gnt0),    32'(g == 0));
    chk("gnt1",    32'(bus.gnt1),    32'(g == 1));
    chk("stall0",  32'(bus.stall0),  32'(r[0] && g != 0));
    chk("stall1",  32'(bus.stall1),  32'(r[1] && g != 1));
    chk("rvalid0", 32'(bus.rvalid0), 32'(rv[0]));
    chk("rvalid1", 32'(bus.rvalid1), 32'(rv[1]));
    chk("rdata0",  bus.rdata0,       rv[0] ? m_pdat[0] : '0);
    chk("rdata1",  bus.rdata1,       rv[1] ? m_pdat[1] : '0);
    chk("ram_wren", 32'(bus.ram_wren), (g >= 0) ? 32'(w[g]) : 32'd0);
    chk("ram_addr", 32'(bus.ram_addr), (g >= 0) ? 32'(a[g]) : 32'd0);
    chk("ram_data", bus.ram_data,      (g >= 0) ? d[g] : '0);
    @(posedge clk);
    if (rst && clken) begin
      for (int x = 0; x < 2; x++) begin
        m_pend[x] = (g == x) && !w[x];
        if (m_pend[x]) m_pdat[x] = shadow[a[x]];
      end
      if (g >= 0 && w[g]) shadow[a[g]] = d[g];
      if (g >= 0) m_lg = g;
      if (m_own < 0) begin
        if (g >= 0 && l[g]) begin
          m_own = g; m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (!l[m_own]) m_own = -1;
        else if (m_cnt == MAXL) begin
          m_lg = m_own; m_own = -1;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit r0, input bit r1, input bit w0, input bit w1,
                       input bit l0, input bit l1, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input bit ce);
    bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
    bus.lock0 = l0; bus.lock1 = l1; bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1; clken = ce;
  endtask

  // asynchronous reset pulse away from the clock edge
  task automatic do_rst();
    rst = 1'b0;
    #1;
    chk("rst_gnt0",    32'(bus.gnt0),     32'd0);
    chk("rst_gnt1",    32'(bus.gnt1),     32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0),  32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1),  32'd0);
    chk("rst_rdata0",  bus.rdata0,        '0);
    chk("rst_rdata1",  bus.rdata1,        '0);
    chk("rst_wren",    32'(bus.ram_wren), 32'd0);
    m_reset();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  bit sl0, sl1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'hA5000000 ^ (i * 32'h00010203);
      shadow[i] = 32'hA5000000 ^ (i * 32'h00010203);
    end
    m_reset();
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 8'h10, 8'h20, '0, '0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt0",   32'(bus.gnt0),     32'd0);
    chk("reset_gnt1",   32'(bus.gnt1),     32'd0);
    chk("reset_rvalid", 32'(bus.rvalid0 | bus.rvalid1), 32'd0);
    chk("reset_wren",   32'(bus.ram_wren), 32'd0);
    rst = 1'b1;

    // both cores reading: core0 first, then alternation
    repeat (4) cyc();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 1);
    cyc();

    // write then read-back of the same word
    drive(1, 0, 1, 0, 0, 0, 8'h05, '0, 32'hDEADBEEF, '0, 1); cyc();
    drive(1, 0, 0, 0, 0, 0, 8'h05, '0, '0, '0, 1);          cyc();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 1);             cyc();
    chk("raw_shadow", shadow[5], 32'hDEADBEEF);

    // core0 single access makes lg=0, then core1 locks for 3 cycles vs req0
    drive(1, 0, 0, 0, 0, 0, 8'h01, '0, '0, '0, 1); cyc();
    drive(1, 1, 0, 0, 0, 1, 8'h02, 8'h03, '0, '0, 1);
    repeat (3) cyc();
    drive(1, 0, 0, 0, 0, 0, 8'h02, '0, '0, '0, 1);
    repeat (2) cyc();

    // core0 locks indefinitely against core1: forced release after MAX_LOCK
    drive(0, 1, 0, 0, 0, 0, '0, 8'h04, '0, '0, 1); cyc();
    drive(1, 1, 0, 0, 1, 0, 8'h06, 8'h07, '0, '0, 1);
    repeat (6) cyc();

    // freeze with a read pending and both requesting
    drive(1, 1, 0, 0, 0, 0, 8'h08, 8'h09, '0, '0, 1); cyc();
    clken = 1'b0; repeat (2) cyc();
    clken = 1'b1; repeat (3) cyc();

    // reset during core1 ownership with a read in flight
    drive(0, 1, 0, 0, 0, 1, '0, 8'h0A, '0, '0, 1); repeat (2) cyc();
    chk("own1_before_rst", 32'(m_own), 32'd1);
    do_rst();
    drive(1, 1, 0, 0, 0, 0, 8'h0B, 8'h0C, '0, '0, 1); repeat (3) cyc();

    // randomized traffic; locks are sticky to exercise forced release
    sl0 = 0; sl1 = 0;
    for (int n = 0; n < 3000; n++) begin
      sl0 = sl0 ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 20);
      sl1 = sl1 ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 20);
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
            1'($urandom), 1'($urandom), sl0, sl1,
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            $urandom, $urandom, $urandom_range(0, 99) < 90);
      if ($urandom_range(0, 199) == 0) do_rst();
      else cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/dcr_dmem_arbiter.md
DCR_DMEM_ARBITER -- requirements
Module: dcr_dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: data RAM word-address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter MAX_LOCK, default 4, legal range 2..15: maximum consecutive cycles one core may hold a lock.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 clken  input  1  global advance enable; 0 freezes all state.
REQ-007 req0, req1  input  1 each  per-core MEM-stage access request.
REQ-008 we0, we1  input  1 each  write (1) / read (0) qualifier of the request.
REQ-009 lock0, lock1  input  1 each  hold-ownership request (read-modify-write sequences).
REQ-010 addr0, addr1  input  ADDR_W each  word address.
REQ-011 wdata0, wdata1  input  DATA_W each  write data.
REQ-012 gnt0, gnt1  output  1 each  access accepted this cycle (combinational).
REQ-013 stall0, stall1  output  1 each  = reqX & ~gntX; freezes core X pipeline.
REQ-014 rvalid0, rvalid1  output  1 each  read data valid for core X (registered).
REQ-015 rdata0, rdata1  output  DATA_W each  read data; equals ram_q when rvalidX, else 0.
REQ-016 ram_wren  output  1  RAM write enable.
REQ-017 ram_addr  output  ADDR_W  RAM address.
REQ-018 ram_data  output  DATA_W  RAM write data.
REQ-019 ram_q  input  DATA_W  RAM read data; synchronous RAM, valid one cycle after address capture.

Function
REQ-020 Arbiter FSM states SHALL be IDLE, OWN0, OWN1; state register, last-grant pointer lg, lock counter lcnt (4 bits), and read-owner tags SHALL be registered.
REQ-021 At most one of gnt0/gnt1 SHALL be 1 in any cycle; no grant SHALL issue when clken=0 or rst=0.
REQ-022 IDLE, single requester: that requester SHALL be granted in the same cycle.
REQ-023 IDLE, both requesting: the core not equal to lg SHALL be granted (round-robin); lg SHALL update to the granted core on each grant.
REQ-024 RAM port SHALL be driven from the granted core: ram_addr=addrX, ram_data=wdataX, ram_wren=weX; with no grant ram_wren=0, ram_addr/ram_data hold 0.
REQ-025 A granted read (weX=0) SHALL assert rvalidX exactly one clken cycle later, with rdataX=ram_q; granted writes SHALL produce no rvalid.
REQ-026 Grant to core X with lockX=1 in IDLE SHALL move FSM to OWNX and load lcnt=1.
REQ-027 In OWNX only core X SHALL be granted; the other core SHALL stall regardless of lg.
REQ-028 In OWNX each clken cycle SHALL increment lcnt, whether or not core X requests (bubble cycles count).
REQ-029 OWNX SHALL return to IDLE on the cycle lockX=0, or forcibly when lcnt reaches MAX_LOCK; on forced release lg SHALL be set to X so the other core wins the next contention.
REQ-030 Release and re-entry: the cycle after returning to IDLE, normal round-robin applies; the releasing core may re-lock only when it wins arbitration.
REQ-031 lockX asserted without reqX, or while the other core owns, SHALL be ignored.
REQ-032 clken=0: FSM, lg, lcnt SHALL hold; rvalid0/1 SHALL deassert; pending read data SHALL be delivered on the next clken=1 cycle only if the RAM output is still held (RAM is clocked with clk, so the integrator keeps address stable; the arbiter keeps the owner tag).

Reset
REQ-033 rst=0 SHALL asynchronously force: state=IDLE, lg=1 (core0 wins first contention), lcnt=0, rvalid0=rvalid1=0, rdata0=rdata1=0, gnt0=gnt1=0, ram_wren=0.
REQ-034 Reset asserted mid-lock or with a read in flight SHALL discard ownership and the pending read; no rvalid SHALL follow reset release.

Verification
REQ-035 After reset, req0=req1=1 reads, addr0=0x10, addr1=0x20 -> gnt0 cycle 1, gnt1 cycle 2, alternating; rvalid0 cycle 2 with RAM[0x10], rvalid1 cycle 3 with RAM[0x20].
REQ-036 core0 writes 0xDEADBEEF to 0x05, next cycle reads 0x05 -> ram_wren=1 cycle 1, rvalid0=1 and rdata0=0xDEADBEEF cycle 3.
REQ-037 core1 lock1=1 with req1 for 3 cycles while req0=1 -> gnt1 3 cycles, stall0=1 throughout, gnt0 the cycle after lock1 drops.
REQ-038 core0 holds lock0=1, req0=1 indefinitely, MAX_LOCK=4, req1=1 -> gnt0 4 cycles, forced release, gnt1 cycle 5.
REQ-039 clken=0 for 2 cycles with both requesting -> no grants, no rvalid, lg unchanged; arbitration resumes identically.
REQ-040 rst pulsed low during OWN1 with read pending -> all outputs 0 immediately; after release core0 wins first contention, no stray rvalid1.
